// File: rtl/lfsr_param.sv
// Parametrised Fibonacci/Galois LFSR with runtime seed load, zero-seed
// lockup protection and hardware period measurement.
module lfsr_param #(
   parameter int              WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS = 16'hB400,
   parameter logic [WIDTH-1:0] SEED = 16'hACE1,
   parameter int              MODE  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] lfsr,
   output logic             out_bit,
   output logic             lockup,
   output logic             period_done,
   output logic [WIDTH-1:0] period_len
);

   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_param: WIDTH must be in 3..32");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_param: SEED must be nonzero");
   end
   if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
      $error("lfsr_param: TAPS[WIDTH-1] must be set");
   end
   if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("lfsr_param: MODE must be 0 or 1");
   end

   // One LFSR step; with TAPS[WIDTH-1] set neither form can map nonzero to zero.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      if (MODE == 0)
         lfsr_step = {s[WIDTH-2:0], ^(s & TAPS)};
      else
         lfsr_step = (s >> 1) ^ (s[0] ? TAPS : '0);
   endfunction

   logic [WIDTH-1:0] start;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] lfsr_nxt;
   logic             seed_zero;

   assign lfsr_nxt  = lfsr_step(lfsr);
   assign seed_zero = (seed_in == '0);
   assign out_bit   = (MODE == 0) ? lfsr[WIDTH-1] : lfsr[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr        <= SEED;
         start       <= SEED;
         cnt         <= '0;
         period_len  <= '0;
         period_done <= 1'b0;
         lockup      <= 1'b0;
      end else if (load) begin
         // A zero seed would lock the register up, so fall back to SEED.
         lfsr        <= seed_zero ? SEED : seed_in;
         start       <= seed_zero ? SEED : seed_in;
         lockup      <= seed_zero;
         cnt         <= '0;
         period_len  <= '0;
         period_done <= 1'b0;
      end else begin
         lockup <= 1'b0;
         if (enable) begin
            lfsr <= lfsr_nxt;
            if (lfsr_nxt == start) begin
               cnt         <= '0;
               period_len  <= cnt + 1'b1;
               period_done <= 1'b1;
            end else begin
               cnt         <= cnt + 1'b1;
               period_done <= 1'b0;
            end
         end else begin
            period_done <= 1'b0;
         end
      end
   end

endmodule
